// File: rtl/output_requantizer.sv
// Requantizes 32-bit C accumulators to int8 Y, plane by plane: bias, scale, round-shift, ReLU, saturate.
// Optional build macro OUTPUT_REQUANT_ACC_CLEAR_EN zeroes each C element one cycle after it is read.
module output_requantizer #(
    parameter int ADDR_WIDTH        = 16,
    parameter int ACC_WIDTH         = 32,
    parameter int DATA_WIDTH        = 8,
    parameter int N_OUT_PLANE_WIDTH = 10,
    parameter int INOUT_WH_WIDTH    = 7,
    parameter int SCALE_WIDTH       = 16,
    parameter int SHIFT_WIDTH       = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_tick,
    input  logic [N_OUT_PLANE_WIDTH-1:0] n_output_plane,
    input  logic [INOUT_WH_WIDTH-1:0]    output_h,
    input  logic [INOUT_WH_WIDTH-1:0]    output_w,
    input  logic [SCALE_WIDTH-1:0]       scale,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    input  logic                         relu_en,
    output logic [ADDR_WIDTH-1:0]        c_rd_addr,
    input  logic [ACC_WIDTH-1:0]         c_in,
    output logic [N_OUT_PLANE_WIDTH-1:0] bias_rd_addr,
    input  logic [ACC_WIDTH-1:0]         bias_in,
    output logic [ADDR_WIDTH-1:0]        y_wr_addr,
    output logic [DATA_WIDTH-1:0]        y_out,
    output logic                         y_wr_en,
    output logic [ADDR_WIDTH-1:0]        c_clr_addr,
    output logic                         c_clr_en,
    output logic                         busy,
    output logic                         done_tick
);

    localparam int SIZE_W = 2 * INOUT_WH_WIDTH;
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int PROD_W = SUM_W + SCALE_WIDTH + 1;
    localparam int RND_W  = PROD_W + 1;

    localparam logic [SIZE_W-1:0]            SIZE_ONE  = SIZE_W'(1);
    localparam logic [N_OUT_PLANE_WIDTH-1:0] PLANE_ONE = N_OUT_PLANE_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]        ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [SHIFT_WIDTH-1:0]       SHIFT_ONE = SHIFT_WIDTH'(1);
    localparam logic signed [RND_W-1:0]      Y_MAX     = RND_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RND_W-1:0]      Y_MIN     = RND_W'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {IDLE, BADDR, BLAT, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [N_OUT_PLANE_WIDTH-1:0] plane, n_planes;
    logic [SIZE_W-1:0]            plane_size, elem, start_size;
    logic [ADDR_WIDTH-1:0]        idx;
    logic signed [ACC_WIDTH-1:0]  bias_reg;
    logic                         last_elem, last_plane;

    logic                         v1, v2, v3;
    logic [ADDR_WIDTH-1:0]        a1, a2, a3;
    logic signed [SUM_W-1:0]      s_reg;
    logic signed [PROD_W-1:0]     prod_reg, s_ext, scale_ext;
    logic signed [RND_W-1:0]      rnd, biased, rounded, clamped;

    assign start_size = {{INOUT_WH_WIDTH{1'b0}}, output_h} * {{INOUT_WH_WIDTH{1'b0}}, output_w};
    assign last_elem  = (elem == plane_size - SIZE_ONE);
    assign last_plane = (plane == n_planes - PLANE_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_tick)
                      state_next = (n_output_plane == '0 || start_size == '0) ? DONE : BADDR;
            BADDR: state_next = BLAT;
            BLAT:  state_next = RUN;
            RUN:   if (last_elem) state_next = last_plane ? DRAIN : BADDR;
            // Elements still in s_reg or prod_reg finish before DONE; the last write lands in the final DRAIN cycle.
            DRAIN: if (!v1 && !v2) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plane      <= '0;
            n_planes   <= '0;
            plane_size <= '0;
            elem       <= '0;
            idx        <= '0;
            bias_reg   <= '0;
        end else begin
            case (state)
                IDLE: if (start_tick) begin
                    plane      <= '0;
                    elem       <= '0;
                    idx        <= '0;
                    n_planes   <= n_output_plane;
                    plane_size <= start_size;
                end
                BLAT: bias_reg <= $signed(bias_in);
                RUN: begin
                    idx <= idx + ADDR_ONE;
                    if (last_elem) begin
                        elem <= '0;
                        if (!last_plane) plane <= plane + PLANE_ONE;
                    end else begin
                        elem <= elem + SIZE_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // bias_reg only changes in BLAT, so the last element of a plane still sees its own bias in the following BADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            a1       <= '0;
            a2       <= '0;
            a3       <= '0;
            s_reg    <= '0;
            prod_reg <= '0;
        end else begin
            v1       <= (state == RUN);
            a1       <= idx;
            v2       <= v1;
            a2       <= a1;
            s_reg    <= SUM_W'($signed(c_in)) + SUM_W'(bias_reg);
            v3       <= v2;
            a3       <= a2;
            prod_reg <= s_ext * scale_ext;
        end
    end

    assign s_ext     = PROD_W'(s_reg);
    assign scale_ext = $signed(PROD_W'(scale));

    always_comb begin
        rnd = '0;
        if (shift != '0) rnd = RND_W'(1) <<< (shift - SHIFT_ONE);
        biased  = RND_W'(prod_reg) + rnd;
        rounded = biased >>> shift;
        clamped = rounded;
        if (relu_en && rounded < 0) clamped = '0;
        if (clamped > Y_MAX)      clamped = Y_MAX;
        else if (clamped < Y_MIN) clamped = Y_MIN;
    end

    assign y_out        = clamped[DATA_WIDTH-1:0];
    assign y_wr_en      = v3;
    assign y_wr_addr    = a3;
    assign c_rd_addr    = idx;
    assign bias_rd_addr = plane;
    assign busy         = (state != IDLE);
    assign done_tick    = (state == DONE);

`ifdef OUTPUT_REQUANT_ACC_CLEAR_EN
    assign c_clr_en   = v1;
    assign c_clr_addr = a1;
`else
    assign c_clr_en   = 1'b0;
    assign c_clr_addr = '0;
`endif

endmodule

// File: tb/tb_output_requantizer.sv
// Randomized scoreboard bench for output_requantizer with a behavioural requantization model and C/bias memory models.
module tb_output_requantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_tick;
    logic [9:0]  n_output_plane;
    logic [6:0]  output_h, output_w;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
    logic [15:0] c_rd_addr;
    logic [31:0] c_in;
    logic [9:0]  bias_rd_addr;
    logic [31:0] bias_in;
    logic [15:0] y_wr_addr;
    logic [7:0]  y_out;
    logic        y_wr_en;
    logic [15:0] c_clr_addr;
    logic        c_clr_en;
    logic        busy;
    logic        done_tick;

    output_requantizer dut (
        .clk(clk), .reset(reset), .start_tick(start_tick),
        .n_output_plane(n_output_plane), .output_h(output_h), .output_w(output_w),
        .scale(scale), .shift(shift), .relu_en(relu_en),
        .c_rd_addr(c_rd_addr), .c_in(c_in), .bias_rd_addr(bias_rd_addr), .bias_in(bias_in),
        .y_wr_addr(y_wr_addr), .y_out(y_out), .y_wr_en(y_wr_en),
        .c_clr_addr(c_clr_addr), .c_clr_en(c_clr_en), .busy(busy), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint addr;
        longint data;
    } exp_t;

    logic signed [31:0] cmem [0:4095];
    logic signed [31:0] bmem [0:1023];
    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   write_count = 0;
    int   clr_count = 0;

`ifdef OUTPUT_REQUANT_ACC_CLEAR_EN
    localparam bit CLEAR_BUILD = 1'b1;
`else
    localparam bit CLEAR_BUILD = 1'b0;
`endif

    // Synchronous-read C and bias memories; the second C port applies clears.
    always @(posedge clk) begin
        c_in    <= cmem[c_rd_addr[11:0]];
        bias_in <= bmem[bias_rd_addr];
        if (c_clr_en) cmem[c_clr_addr[11:0]] <= '0;
    end

    function automatic void check(string name, longint actual, longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    function automatic longint ref_y(longint c, longint b, int sc, int sh, bit relu);
        longint r;
        r = (c + b) * longint'(sc);
        if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Monitor: every Y write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (c_clr_en) clr_count++;
        if (y_wr_en) begin
            write_count++;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("y_addr", longint'(y_wr_addr), mon_e.addr);
                check("y_data", longint'($signed(y_out)), mon_e.data);
            end
        end
    end

    task automatic set_job(int n, int h, int w, int sc, int sh, bit relu);
        n_output_plane = 10'(n);
        output_h       = 7'(h);
        output_w       = 7'(w);
        scale          = 16'(sc);
        shift          = 5'(sh);
        relu_en        = relu;
        for (int p = 0; p < n; p++)
            for (int i = 0; i < h * w; i++)
                sb.push_back('{longint'(p * h * w + i),
                               ref_y(longint'(cmem[p * h * w + i]), longint'(bmem[p]), sc, sh, relu)});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start_tick = 1'b1;
        @(posedge clk);
        #1 start_tick = 1'b0;
    endtask

    task automatic check_output(string tag);
        check({tag, "_y_wr_en"}, longint'(y_wr_en), 0);
        check({tag, "_y_out"}, longint'(y_out), 0);
        check({tag, "_y_wr_addr"}, longint'(y_wr_addr), 0);
        check({tag, "_c_rd_addr"}, longint'(c_rd_addr), 0);
        check({tag, "_bias_rd_addr"}, longint'(bias_rd_addr), 0);
        check({tag, "_c_clr_en"}, longint'(c_clr_en), 0);
        check({tag, "_c_clr_addr"}, longint'(c_clr_addr), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done_tick"}, longint'(done_tick), 0);
    endtask

    task automatic apply_stimulus(int n, int h, int w, int sc, int sh, bit relu, bit extra_start);
        int cyc;
        int clr_base;
        int nz;
        int total;
        total = n * h * w;
        set_job(n, h, w, sc, sh, relu);
        clr_base = clr_count;
        pulse_start();
        cyc = 1;
        while (!done_tick && cyc < 5000) begin
            start_tick = extra_start && (cyc == 3);
            @(posedge clk);
            #1 cyc++;
        end
        start_tick = 1'b0;
        check("done_seen", longint'(done_tick), 1);
        check("cycles", cyc, (total == 0) ? 1 : n * (h * w + 2) + 4);
        @(posedge clk);
        #1;
        check("done_one_cycle", longint'(done_tick), 0);
        check("idle_after_done", longint'(busy), 0);
        check("sb_empty", sb.size(), 0);
        sb.delete();
        check("clear_count", clr_count - clr_base, CLEAR_BUILD ? total : 0);
        if (CLEAR_BUILD && total > 0) begin
            nz = 0;
            for (int a = 0; a < total; a++) if (cmem[a] != 0) nz++;
            check("c_cleared", nz, 0);
        end
    endtask

    task automatic load_test4();
        for (int a = 0; a < 6; a++) cmem[a] = 1;
        bmem[0] = 0;
        bmem[1] = 100;
        bmem[2] = -100;
    endtask

    initial begin
        int wc;
        int k;
        int wbase;
        int n, h, w;
        reset = 1'b1;
        start_tick = 1'b0;
        set_job(0, 0, 0, 0, 0, 1'b0);
        for (int a = 0; a < 4096; a++) cmem[a] = '0;
        for (int a = 0; a < 1024; a++) bmem[a] = '0;
        repeat (3) @(posedge clk);
        #1 check_output("reset");
        reset = 1'b0;

        cmem[0] = 10; cmem[1] = -20; cmem[2] = 300; cmem[3] = -300; bmem[0] = 5;
        apply_stimulus(1, 2, 2, 1, 0, 1'b0, 1'b0);

        cmem[0] = 7; cmem[1] = -7; cmem[2] = 6; bmem[0] = 0;
        apply_stimulus(1, 1, 3, 3, 2, 1'b0, 1'b0);

        cmem[0] = -50; cmem[1] = 50; cmem[2] = 0; cmem[3] = 1000; bmem[0] = 0;
        apply_stimulus(1, 2, 2, 1, 0, 1'b1, 1'b0);

        load_test4();
        apply_stimulus(3, 1, 2, 1, 0, 1'b0, 1'b0);

        load_test4();
        apply_stimulus(3, 1, 2, 1, 0, 1'b0, 1'b1);

        apply_stimulus(0, 2, 2, 1, 0, 1'b0, 1'b0);
        apply_stimulus(2, 0, 3, 1, 0, 1'b0, 1'b0);

        // Abort test 4 after its second write, then rerun it from scratch.
        load_test4();
        set_job(3, 1, 2, 1, 0, 1'b0);
        pulse_start();
        wc = 0;
        k = 0;
        while (wc < 2 && k < 200) begin
            if (y_wr_en) wc++;
            if (wc < 2) begin
                @(posedge clk);
                #1 k++;
            end
        end
        check("abort_writes_seen", wc, 2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_output("abort");
        sb.delete();
        wbase = write_count;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("no_writes_after_abort", write_count - wbase, 0);
        load_test4();
        apply_stimulus(3, 1, 2, 1, 0, 1'b0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 3);
            h = $urandom_range(1, 4);
            w = $urandom_range(1, 4);
            for (int a = 0; a < n * h * w; a++)
                cmem[a] = ($urandom_range(0, 3) == 0) ? $signed($urandom) : 32'(int'($urandom_range(0, 600)) - 300);
            for (int p = 0; p < n; p++)
                bmem[p] = ($urandom_range(0, 3) == 0) ? $signed($urandom) : 32'(int'($urandom_range(0, 200)) - 100);
            apply_stimulus(n, h, w,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 8)),
                           int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
